ysyx_25020047_mem_arbiter: RTL and testbench
============================================

# ysyx_25020047_mem_arbiter

Shares the core's single memory port between instruction fetch (IFU) and the load/store path driven by the EXU `read`/`write` flags (LSU). Arbitrates with round-robin on ties, holds the grant for exactly one outstanding transaction, and returns each response to the requester that issued it. An optional response timeout converts a hung memory into an error response. Sits between the IFU/LSU and the external memory bus.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `wmask` is `DATA_W/8` bits
- `TIMEOUT`, 255, max cycles spent in REQ+WAIT before abort; 0 disables the timeout

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `ifu_req_valid` in 1 / `ifu_req_ready` out 1 / `ifu_addr` in ADDR_W: fetch request, always a read
- `ifu_rsp_valid` out 1 / `ifu_rdata` out DATA_W / `ifu_rsp_err` out 1: fetch response
- `lsu_req_valid` in 1 / `lsu_req_ready` out 1 / `lsu_addr` in ADDR_W: load/store request
- `lsu_wen` in 1 / `lsu_wdata` in DATA_W / `lsu_wmask` in DATA_W/8: 1 = store; byte strobes (`sb` = one bit, `sw` = all bits)
- `lsu_rsp_valid` out 1 / `lsu_rdata` out DATA_W / `lsu_rsp_err` out 1: load/store response; stores also get a response
- `mem_req_valid` out 1 / `mem_req_ready` in 1 / `mem_addr` out ADDR_W / `mem_wen` out 1 / `mem_wdata` out DATA_W / `mem_wmask` out DATA_W/8: memory request
- `mem_rsp_valid` in 1 / `mem_rdata` in DATA_W / `mem_rsp_err` in 1: memory response
- `busy` out 1: state != IDLE
- `owner` out 1: current or last grant, 0 = IFU, 1 = LSU

## Operation
- States:
  - IDLE: waiting for a request.
  - REQ: `mem_req_valid`=1, waiting for `mem_req_ready`.
  - WAIT: waiting for `mem_rsp_valid`.
  - RESP: one-cycle response pulse to the owner, then back to IDLE.
- Grant (IDLE only, combinational): `ifu_req_ready` and `lsu_req_ready` are 1 only in IDLE.
  - One requester valid: that requester is granted.
  - Both valid: the requester not granted last time wins. `last_owner` resets to IFU, so the first tie goes to LSU.
  - At most one `*_req_ready` is high in any cycle.
- On the accept handshake:
  - Latch addr, wen, wdata and wmask into the request registers, and latch `owner`.
  - IFU requests latch wen=0 and wmask=0.
  - LSU loads force wmask=0 regardless of `lsu_wmask`.
  - Go to REQ.
- REQ: `mem_*` request outputs come only from the registers and stay stable until `mem_req_ready`=1. Handshake → WAIT.
- WAIT: `mem_rsp_valid`=1 latches `mem_rdata`/`mem_rsp_err` into the owner's response registers → RESP.
- Stray responses: `mem_rsp_valid` in IDLE, REQ or RESP is ignored.
- Timeout (TIMEOUT>0):
  - A counter clears on accept and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT with no completion: go to RESP with rdata=0 and err=1, and drop `mem_req_valid`.
  - Memory must not answer an aborted transaction later.
- Response outputs hold their last value between pulses. Only `*_rsp_valid` is qualified.
- Sources never see back-pressure on responses; requesters must accept `*_rsp_valid` in the cycle it is asserted.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - All outputs go to 0 next cycle: valid/ready/err/data/addr/mask, `busy`, and `owner`=0.
  - State → IDLE, counter = 0, `last_owner` = IFU.
- Reset mid-transaction: abandon the transaction, drop `mem_req_valid` at that edge, and issue no response.
- Latency, with the accept at cycle T:
  - `mem_req_valid` high from T+1.
  - If `mem_req_ready`=1 at T+1 and `mem_rsp_valid`=1 at T+2, then `*_rsp_valid` pulses at T+3.
  - Minimum accept-to-response is 3 cycles. Each cycle of memory stall adds 1.
- Throughput: the next accept is possible at earliest in the RESP cycle + 1 (IDLE), so at most one transaction per 4 cycles.
- `mem_rsp_valid` asserted in the same cycle as the `mem_req_ready` handshake is ignored. Memory responds at least 1 cycle after the handshake.
- Timeout: with `mem_req_ready` stuck at 0, the error response pulses TIMEOUT+1 cycles after T+1.

## Test plan
- Single fetch: `ifu_addr`=0x80000000, memory ready immediately, `mem_rdata`=0x00100093 at T+2 → `ifu_rsp_valid` at T+3, `ifu_rdata`=0x00100093, err=0, `lsu_rsp_valid` stays 0.
- Store byte: `lsu_wen`=1, addr 0x80001003, wdata 0x000000AB, wmask 0b1000 → `mem_wen`=1, `mem_wmask`=0b1000, `mem_addr`=0x80001003 held for 3 cycles of `mem_req_ready`=0, then `lsu_rsp_valid` pulses once.
- Simultaneous requests on 3 consecutive arbitration rounds from reset → grant order LSU, IFU, LSU. `owner` is 1, 0, 1, and no cycle has both ready signals high.
- Load with `lsu_wmask`=0xF → `mem_wmask`=0 and `mem_wen`=0. `mem_rdata`=0xDEADBEEF → `lsu_rdata`=0xDEADBEEF.
- TIMEOUT=8, `mem_req_ready` held 0 → after 9 cycles in REQ, `ifu_rsp_valid`=1, `ifu_rsp_err`=1, `ifu_rdata`=0, `busy`→0. A stray `mem_rsp_valid` in the following IDLE produces no response.
- `rst_n` pulled low while in WAIT → next cycle `mem_req_valid`=0, `busy`=0, no `*_rsp_valid`. A new IFU request after release completes normally.

Source files
------------

// File: rtl/ysyx_25020047_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020047_mem_arbiter
// Brief    : Shares one memory port between IFU and LSU, one outstanding txn.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020047_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_ifu_req_valid,
    output logic                o_ifu_req_ready,
    input  logic [ADDR_W-1:0]   i_ifu_addr,
    output logic                o_ifu_rsp_valid,
    output logic [DATA_W-1:0]   o_ifu_rdata,
    output logic                o_ifu_rsp_err,
    input  logic                i_lsu_req_valid,
    output logic                o_lsu_req_ready,
    input  logic [ADDR_W-1:0]   i_lsu_addr,
    input  logic                i_lsu_wen,
    input  logic [DATA_W-1:0]   i_lsu_wdata,
    input  logic [DATA_W/8-1:0] i_lsu_wmask,
    output logic                o_lsu_rsp_valid,
    output logic [DATA_W-1:0]   o_lsu_rdata,
    output logic                o_lsu_rsp_err,
    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_wen,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    input  logic                i_mem_rsp_valid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    input  logic                i_mem_rsp_err,
    output logic                o_busy,
    output logic                o_owner
);

    localparam int c_MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_wen;
    logic [DATA_W-1:0]     r_wdata;
    logic [c_MASK_W-1:0]   r_wmask;
    logic [DATA_W-1:0]     r_ifu_rdata;
    logic                  r_ifu_err;
    logic [DATA_W-1:0]     r_lsu_rdata;
    logic                  r_lsu_err;

    logic                  w_idle;
    logic                  w_grant_lsu;
    logic                  w_grant_ifu;
    logic                  w_accept;
    logic                  w_active;
    logic                  w_complete;
    logic                  w_timeout;

    // r_owner doubles as the last grant: on a tie the other requester wins.
    assign w_idle      = (r_state == S_IDLE);
    assign w_grant_lsu = i_lsu_req_valid && (!i_ifu_req_valid || !r_owner);
    assign w_grant_ifu = i_ifu_req_valid && !w_grant_lsu;
    assign w_accept    = w_idle && (w_grant_lsu || w_grant_ifu);
    assign w_active    = (r_state == S_REQ) || (r_state == S_WAIT);
    assign w_complete  = (r_state == S_WAIT) && i_mem_rsp_valid;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int c_CNT_W = $clog2(TIMEOUT + 1);
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt <= '0;
                end else if (w_active) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_timeout = w_active && (r_cnt == c_CNT_W'(TIMEOUT));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A real response landing on the timeout cycle takes priority over abort.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_timeout) begin
                    w_state_nxt = S_RESP;
                end else if (i_mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: if (i_mem_rsp_valid || w_timeout) w_state_nxt = S_RESP;
            S_RESP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner     <= 1'b0;
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_ifu_rdata <= '0;
            r_ifu_err   <= 1'b0;
            r_lsu_rdata <= '0;
            r_lsu_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant_lsu;
                r_addr  <= w_grant_lsu ? i_lsu_addr : i_ifu_addr;
                r_wen   <= w_grant_lsu && i_lsu_wen;
                r_wdata <= w_grant_lsu ? i_lsu_wdata : '0;
                r_wmask <= (w_grant_lsu && i_lsu_wen) ? i_lsu_wmask : '0;
            end
            if (w_complete) begin
                if (r_owner) begin
                    r_lsu_rdata <= i_mem_rdata;
                    r_lsu_err   <= i_mem_rsp_err;
                end else begin
                    r_ifu_rdata <= i_mem_rdata;
                    r_ifu_err   <= i_mem_rsp_err;
                end
            end else if (w_timeout) begin
                if (r_owner) begin
                    r_lsu_rdata <= '0;
                    r_lsu_err   <= 1'b1;
                end else begin
                    r_ifu_rdata <= '0;
                    r_ifu_err   <= 1'b1;
                end
            end
        end
    end

    assign o_ifu_req_ready = w_idle && w_grant_ifu;
    assign o_lsu_req_ready = w_idle && w_grant_lsu;
    assign o_ifu_rsp_valid = (r_state == S_RESP) && !r_owner;
    assign o_lsu_rsp_valid = (r_state == S_RESP) && r_owner;
    assign o_ifu_rdata     = r_ifu_rdata;
    assign o_ifu_rsp_err   = r_ifu_err;
    assign o_lsu_rdata     = r_lsu_rdata;
    assign o_lsu_rsp_err   = r_lsu_err;
    assign o_mem_req_valid = (r_state == S_REQ);
    assign o_mem_addr      = r_addr;
    assign o_mem_wen       = r_wen;
    assign o_mem_wdata     = r_wdata;
    assign o_mem_wmask     = r_wmask;
    assign o_busy          = !w_idle;
    assign o_owner         = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25020047_mem_arbiter
// Brief    : Directed scoreboard bench for the IFU/LSU memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25020047_mem_arbiter;

    typedef struct packed {
        logic        lsu;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        busy, owner;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    ysyx_25020047_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_ifu_req_valid(ifu_req_valid), .o_ifu_req_ready(ifu_req_ready),
        .i_ifu_addr(ifu_addr), .o_ifu_rsp_valid(ifu_rsp_valid),
        .o_ifu_rdata(ifu_rdata), .o_ifu_rsp_err(ifu_rsp_err),
        .i_lsu_req_valid(lsu_req_valid), .o_lsu_req_ready(lsu_req_ready),
        .i_lsu_addr(lsu_addr), .i_lsu_wen(lsu_wen), .i_lsu_wdata(lsu_wdata),
        .i_lsu_wmask(lsu_wmask), .o_lsu_rsp_valid(lsu_rsp_valid),
        .o_lsu_rdata(lsu_rdata), .o_lsu_rsp_err(lsu_rsp_err),
        .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready),
        .o_mem_addr(mem_addr), .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata),
        .o_mem_wmask(mem_wmask), .i_mem_rsp_valid(mem_rsp_valid),
        .i_mem_rdata(mem_rdata), .i_mem_rsp_err(mem_rsp_err),
        .o_busy(busy), .o_owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        #2;
        chk("ready_onehot", {63'd0, ifu_req_ready & lsu_req_ready}, 64'd0);
        chk("spurious_rsp", {63'd0, (ifu_rsp_valid | lsu_rsp_valid) && (sb.size() == 0)}, 64'd0);
        if ((ifu_rsp_valid || lsu_rsp_valid) && sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_lsu_valid", {63'd0, lsu_rsp_valid}, {63'd0, e.lsu});
            chk("rsp_ifu_valid", {63'd0, ifu_rsp_valid}, {63'd0, !e.lsu});
            chk("rsp_rdata", {32'd0, e.lsu ? lsu_rdata : ifu_rdata}, {32'd0, e.rdata});
            chk("rsp_err", {63'd0, e.lsu ? lsu_rsp_err : ifu_rsp_err}, {63'd0, e.err});
        end
    end

    // One full transaction; called right after a falling edge while in IDLE.
    task automatic run_txn(input string tag, input bit both, input bit win_lsu,
                           input logic [31:0] addr, input bit wen,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           input int stall, input logic [31:0] rdata,
                           input bit err, input logic [3:0] exp_mask);
        exp_t e;
        ifu_req_valid = both || !win_lsu;
        lsu_req_valid = both || win_lsu;
        ifu_addr      = win_lsu ? 32'h1111_0000 : addr;
        lsu_addr      = win_lsu ? addr : 32'h2222_0000;
        lsu_wen       = wen;
        lsu_wdata     = wdata;
        lsu_wmask     = wmask;
        #1;
        chk({tag, "_lsu_ready"}, {63'd0, lsu_req_ready}, {63'd0, win_lsu});
        chk({tag, "_ifu_ready"}, {63'd0, ifu_req_ready}, {63'd0, !win_lsu});
        e.lsu = win_lsu; e.rdata = rdata; e.err = err;
        sb.push_back(e);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        chk({tag, "_mem_valid"}, {63'd0, mem_req_valid}, 64'd1);
        chk({tag, "_owner"}, {63'd0, owner}, {63'd0, win_lsu});
        chk({tag, "_mem_addr"}, {32'd0, mem_addr}, {32'd0, addr});
        chk({tag, "_mem_wen"}, {63'd0, mem_wen}, {63'd0, win_lsu & wen});
        chk({tag, "_mem_wmask"}, {60'd0, mem_wmask}, {60'd0, exp_mask});
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        if (win_lsu && wen) chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, {32'd0, wdata});
        for (int i = 0; i < stall; i++) begin
            mem_req_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_stall_valid"}, {63'd0, mem_req_valid}, 64'd1);
            chk({tag, "_stall_addr"}, {32'd0, mem_addr}, {32'd0, addr});
            chk({tag, "_stall_wmask"}, {60'd0, mem_wmask}, {60'd0, exp_mask});
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk({tag, "_wait_valid"}, {63'd0, mem_req_valid}, 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        mem_rsp_err   = err;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0BAD_0BAD;
        mem_rsp_err   = 1'b0;
        chk({tag, "_rsp_latency"}, {63'd0, win_lsu ? lsu_rsp_valid : ifu_rsp_valid}, 64'd1);
        @(negedge clk);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0;
        lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rdata = '0; mem_rsp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_owner", {63'd0, owner}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_mem_wmask", {60'd0, mem_wmask}, 64'd0);
        chk("rst_ifu_rdata", {32'd0, ifu_rdata}, 64'd0);
        chk("rst_lsu_err", {63'd0, lsu_rsp_err}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three ties from reset: LSU, IFU, LSU.
        run_txn("tie1", 1'b1, 1'b1, 32'h8000_2000, 1'b0, 32'h0, 4'h0, 0, 32'h0000_0011, 1'b0, 4'h0);
        run_txn("tie2", 1'b1, 1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 0, 32'h0000_0022, 1'b0, 4'h0);
        run_txn("tie3", 1'b1, 1'b1, 32'h8000_2004, 1'b0, 32'h0, 4'h0, 0, 32'h0000_0033, 1'b0, 4'h0);

        run_txn("fetch", 1'b0, 1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 32'h0010_0093, 1'b0, 4'h0);
        run_txn("sb", 1'b0, 1'b1, 32'h8000_1003, 1'b1, 32'h0000_00AB, 4'b1000, 3, 32'h0, 1'b0, 4'b1000);
        run_txn("lw", 1'b0, 1'b1, 32'h8000_1000, 1'b0, 32'h1234_5678, 4'hF, 1, 32'hDEAD_BEEF, 1'b0, 4'h0);
        run_txn("lerr", 1'b0, 1'b1, 32'h8000_1010, 1'b0, 32'h0, 4'h0, 0, 32'h0000_0044, 1'b1, 4'h0);

        // Timeout with memory never ready.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0100;
        #1;
        chk("tmo_ready", {63'd0, ifu_req_ready}, 64'd1);
        sb.push_back('{lsu: 1'b0, rdata: 32'h0, err: 1'b1});
        @(negedge clk);
        ifu_req_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            chk("tmo_req_held", {63'd0, mem_req_valid}, 64'd1);
            chk("tmo_no_rsp_early", {63'd0, ifu_rsp_valid}, 64'd0);
            @(negedge clk);
        end
        chk("tmo_rsp", {63'd0, ifu_rsp_valid}, 64'd1);
        chk("tmo_req_dropped", {63'd0, mem_req_valid}, 64'd0);
        @(negedge clk);
        chk("tmo_idle", {63'd0, busy}, 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h5555_5555;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("stray_idle", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("stray_no_rsp", {63'd0, ifu_rsp_valid}, 64'd0);
        chk("stray_rdata_held", {32'd0, ifu_rdata}, 64'd0);

        // Reset while waiting for the memory response.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0200;
        #1;
        chk("rstw_ready", {63'd0, ifu_req_ready}, 64'd1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rstw_in_wait", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstw_mem_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rstw_busy", {63'd0, busy}, 64'd0);
        chk("rstw_owner", {63'd0, owner}, 64'd0);
        chk("rstw_no_rsp", {63'd0, ifu_rsp_valid | lsu_rsp_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw_after_idle", {63'd0, busy}, 64'd0);
        run_txn("refetch", 1'b0, 1'b0, 32'h8000_0008, 1'b0, 32'h0, 4'h0, 0, 32'h0000_0513, 1'b0, 4'h0);

        repeat (2) @(negedge clk);
        #3;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
